// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } lu_state_t;

  function automatic logic [7:0] size_mask(mem_size_t size);
    case (size)
      SZ_BYTE:  size_mask = 8'h01;
      SZ_HALF:  size_mask = 8'h03;
      SZ_WORD:  size_mask = 8'h0F;
      default:  size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/wb_load_unit_if.sv
// Wishbone bus bundle between a master and the interconnect.
interface wb_bus_t #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic              wb_lock;
  logic              wb_tgc;
  logic              wb_tga;
  logic              wb_tgd_ms;
  logic [ADDR_W-1:0] wb_adr;
  logic [SEL_W-1:0]  wb_sel;
  logic [DATA_W-1:0] wb_dat_ms;
  logic [DATA_W-1:0] wb_dat_sm;
  logic              wb_ack;
  logic              wb_gnt;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_lock, wb_tgc, wb_tga, wb_tgd_ms,
           wb_adr, wb_sel, wb_dat_ms,
    input  wb_dat_sm, wb_ack, wb_gnt
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_lock, wb_tgc, wb_tga, wb_tgd_ms,
           wb_adr, wb_sel, wb_dat_ms,
    output wb_dat_sm, wb_ack, wb_gnt
  );

endinterface

// File: rtl/wb_load_unit_load_align.sv
// Lane extraction plus sign/zero extension; shared with the store path's read-modify-write.
module load_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]            data,
  input  logic [$clog2(DATA_W/8)-1:0]  offset,
  input  mem_size_t                    size,
  input  logic                         zero_ext,
  output logic [DATA_W-1:0]            result
);

  logic [DATA_W-1:0] lane;
  logic              sign;
  int                nbits;

  always_comb begin
    lane   = data >> {offset, 3'b000};
    nbits  = DATA_W;
    sign   = lane[DATA_W-1];
    result = '0;
    case (size)
      SZ_BYTE: begin nbits = 8;  sign = lane[7];  end
      SZ_HALF: begin nbits = 16; sign = lane[15]; end
      SZ_WORD: begin nbits = 32; sign = lane[31]; end
      default: begin nbits = DATA_W; sign = lane[DATA_W-1]; end
    endcase
    for (int i = 0; i < DATA_W; i++)
      result[i] = (i < nbits) ? lane[i] : (sign & ~zero_ext);
  end

endmodule

// File: rtl/wb_load_unit.sv
// Wishbone single-read load unit. Optional bus timeout enabled by defining WB_LOAD_TIMEOUT_EN.
//  state | meaning
//  IDLE  | ready for a request; misaligned/illegal requests answered with err here
//  BUS   | Wishbone read cycle open, waiting for a granted ack
module wb_load_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  wb_bus_t.master           wb_bus
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int SEL_W = DATA_W / 8;

  lu_state_t         state;
  logic [ADDR_W-1:0] addr_q;
  mem_size_t         size_q;
  logic              uns_q;
  logic [OFF_W-1:0]  offset_q;
  logic [SEL_W-1:0]  sel_base;
  logic              ack_ok;
  logic              bad_req;
  logic [DATA_W-1:0] ext_data;
`ifdef WB_LOAD_TIMEOUT_EN
  logic [15:0]       tmo_cnt;
`endif

  assign offset_q = addr_q[OFF_W-1:0];
  assign sel_base = SEL_W'(size_mask(size_q));
  assign ready_o  = (state == IDLE);

  assign wb_bus.wb_cyc    = (state == BUS);
  assign wb_bus.wb_stb    = (state == BUS) && wb_bus.wb_gnt;
  assign wb_bus.wb_sel    = wb_bus.wb_stb ? (sel_base << offset_q) : '0;
  assign wb_bus.wb_adr    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign wb_bus.wb_we     = 1'b0;
  assign wb_bus.wb_lock   = 1'b0;
  assign wb_bus.wb_tgc    = 1'b0;
  assign wb_bus.wb_tga    = 1'b0;
  assign wb_bus.wb_tgd_ms = 1'b0;
  assign wb_bus.wb_dat_ms = '0;

  // an ack only counts when this master actually holds the strobe
  assign ack_ok = wb_bus.wb_stb && wb_bus.wb_ack;

  always_comb begin
    bad_req = 1'b0;
    case (mem_size_t'(size_i))
      SZ_HALF:  bad_req = addr_i[0];
      SZ_WORD:  bad_req = |addr_i[1:0];
      SZ_DWORD: bad_req = (DATA_W != 64) || (|addr_i[2:0]);
      default:  bad_req = 1'b0;
    endcase
  end

  load_align #(.DATA_W(DATA_W)) u_align (
    .data     (wb_bus.wb_dat_sm),
    .offset   (offset_q),
    .size     (size_q),
    .zero_ext (uns_q),
    .result   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      data_o  <= '0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            addr_q <= addr_i;
            size_q <= mem_size_t'(size_i);
            uns_q  <= unsigned_i;
            if (bad_req) begin
              valid_o <= 1'b1;
              err_o   <= 1'b1;
              data_o  <= '0;
            end else begin
              state <= BUS;
`ifdef WB_LOAD_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
        end
        BUS: begin
          if (ack_ok) begin
            data_o  <= ext_data;
            valid_o <= 1'b1;
            state   <= IDLE;
          end
`ifdef WB_LOAD_TIMEOUT_EN
          else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
            data_o  <= '0;
            valid_o <= 1'b1;
            err_o   <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
